// File: rtl/vga_draw_scheduler_pkg.sv
// rtl/vga_draw_scheduler_pkg.sv - shared encodings and plot-bus types for the VGA draw scheduler
//
// Purpose: state and grant encodings plus the plot-bus field widths used by
//          the scheduler top and its plot-bus multiplexer.
// Ports:   none (package).

package vga_draw_scheduler_pkg;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int RGB_W  = 24;
  localparam int ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR_GO    = 3'd1,
    ST_CLR_WAIT  = 3'd2,
    ST_TILE_GO   = 3'd3,
    ST_TILE_WAIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_CLR  = 2'd1,
    GRANT_TILE = 2'd2
  } grant_t;

  // One engine's view of the vga_adapter plot port.
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [RGB_W-1:0] rgb;
    logic             plot;
  } plot_bus_t;

  // Wait states are the only states in which the watchdog runs.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_CLR_WAIT) || (s == ST_TILE_WAIT);
  endfunction

endpackage

// File: rtl/vga_draw_scheduler_plot_bus_mux.sv
// rtl/vga_draw_scheduler_plot_bus_mux.sv - grant-selected 2:1 plot bus multiplexer
//
// Purpose: forwards exactly one engine's plot bus to the vga_adapter. The
//          non-granted engine is ignored entirely; with no grant the output
//          bus is all zero so nothing is plotted.
// Ports:
//   grant    in   grant_t     registered grant from the scheduler
//   clr_bus  in   plot_bus_t  clear engine plot bus
//   td_bus   in   plot_bus_t  tile drawer plot bus
//   vga_bus  out  plot_bus_t  bus driven to the vga_adapter

module vga_draw_scheduler_plot_bus_mux
  import vga_draw_scheduler_pkg::*;
(
  input  grant_t    grant,
  input  plot_bus_t clr_bus,
  input  plot_bus_t td_bus,
  output plot_bus_t vga_bus
);

  always_comb begin
    vga_bus = '0;
    case (grant)
      GRANT_CLR:  vga_bus = clr_bus;
      GRANT_TILE: vga_bus = td_bus;
      default:    vga_bus = '0;
    endcase
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// rtl/vga_draw_scheduler.sv - per-frame sequencer and plot-port arbiter for clear and tile engines
//
// Purpose: on each accepted frame tick runs the clear engine once, then the
//          tile drawer once per tile, granting the single vga_adapter plot
//          port to one engine at a time through a registered grant.
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   frame_tick, tile_count            frame start pulse and tiles to draw
//   tile_idx / tile_addr,x,y          tile table lookup (index out, data in)
//   clr_start, clr_done               clear engine handshake
//   clr_x, clr_y, clr_rgb, clr_plot   clear engine plot bus
//   td_start, td_done                 tile drawer handshake
//   td_addr, td_x, td_y               registered tile parameters to the drawer
//   td_x_o, td_y_o, td_rgb, td_plot   tile drawer plot bus
//   vga_x, vga_y, vga_rgb, vga_plot   plot bus to the vga_adapter
//   busy, overrun, wd_abort           status

module vga_draw_scheduler
  import vga_draw_scheduler_pkg::*;
#(
  parameter int MAX_TILES       = 4,
  parameter int WATCHDOG_CYCLES = 65536,
  localparam int IDX_W = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1,
  localparam int CNT_W = $clog2(MAX_TILES + 1),
  localparam int WD_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_tick,
  input  logic [2:0]        tile_count,
  output logic [IDX_W-1:0]  tile_idx,
  input  logic [ADDR_W-1:0] tile_addr,
  input  logic [X_W-1:0]    tile_x,
  input  logic [Y_W-1:0]    tile_y,
  output logic              clr_start,
  input  logic              clr_done,
  input  logic [X_W-1:0]    clr_x,
  input  logic [Y_W-1:0]    clr_y,
  input  logic [RGB_W-1:0]  clr_rgb,
  input  logic              clr_plot,
  output logic              td_start,
  output logic [ADDR_W-1:0] td_addr,
  output logic [X_W-1:0]    td_x,
  output logic [Y_W-1:0]    td_y,
  input  logic              td_done,
  input  logic [X_W-1:0]    td_x_o,
  input  logic [Y_W-1:0]    td_y_o,
  input  logic [RGB_W-1:0]  td_rgb,
  input  logic              td_plot,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic              vga_plot,
  output logic              busy,
  output logic              overrun,
  output logic              wd_abort
);

  state_t            state, state_d;
  grant_t            grant, grant_d;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  count;
  logic [WD_W-1:0]   wd;
  logic              td_start_q;
  logic              overrun_q;
  logic              wd_expired;
  logic              tile_last;
  logic [CNT_W-1:0]  count_clamped;

  plot_bus_t clr_bus, td_bus, vga_bus;

  assign wd_expired = (wd == WD_W'(WATCHDOG_CYCLES - 1));
  assign tile_last  = ((CNT_W'(idx) + CNT_W'(1)) == count);

  assign count_clamped = (int'(tile_count) > MAX_TILES) ? CNT_W'(MAX_TILES)
                                                        : CNT_W'(tile_count);

  // Next-state and combinational outputs.
  always_comb begin
    state_d   = state;
    clr_start = 1'b0;
    wd_abort  = 1'b0;
    busy      = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (frame_tick) state_d = ST_CLR_GO;
      end
      ST_CLR_GO: begin
        clr_start = 1'b1;
        state_d   = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        // The watchdog wins over a done arriving in the same cycle so the
        // abort pulse never depends combinationally on an engine input.
        if (wd_expired) begin
          wd_abort = 1'b1;
          state_d  = ST_IDLE;
        end else if (clr_done) begin
          state_d = (count == '0) ? ST_IDLE : ST_TILE_GO;
        end
      end
      ST_TILE_GO: begin
        state_d = ST_TILE_WAIT;
      end
      ST_TILE_WAIT: begin
        if (wd_expired) begin
          wd_abort = 1'b1;
          state_d  = ST_IDLE;
        end else if (td_done) begin
          state_d = tile_last ? ST_IDLE : ST_TILE_GO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant follows the state being entered, so it is registered and only
  // changes on state entry.
  always_comb begin
    grant_d = GRANT_NONE;
    case (state_d)
      ST_CLR_WAIT:  grant_d = GRANT_CLR;
      ST_TILE_WAIT: grant_d = GRANT_TILE;
      default:      grant_d = GRANT_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      grant <= GRANT_NONE;
    end else begin
      state <= state_d;
      grant <= grant_d;
    end
  end

  // Tile index and frame tile count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx   <= '0;
      count <= '0;
    end else begin
      if (state == ST_IDLE && frame_tick) count <= count_clamped;

      if (state_d == ST_IDLE) begin
        idx <= '0;
      end else if (state == ST_CLR_WAIT && state_d == ST_TILE_GO) begin
        idx <= '0;
      end else if (state == ST_TILE_WAIT && state_d == ST_TILE_GO) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Watchdog: cleared on entry to a wait state, counts every wait cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd <= '0;
    end else if (is_wait_state(state_d) && (state_d != state)) begin
      wd <= '0;
    end else if (is_wait_state(state) && is_wait_state(state_d)) begin
      wd <= wd + WD_W'(1);
    end else begin
      wd <= '0;
    end
  end

  // Tile parameters load at the end of TILE_GO from the lookup at the
  // current index; td_start is registered from the same condition so the
  // drawer sees the pulse together with already-stable parameters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      td_addr    <= '0;
      td_x       <= '0;
      td_y       <= '0;
      td_start_q <= 1'b0;
    end else begin
      td_start_q <= (state == ST_TILE_GO);
      if (state == ST_TILE_GO) begin
        td_addr <= tile_addr;
        td_x    <= tile_x;
        td_y    <= tile_y;
      end
    end
  end

  // Sticky overrun: any frame tick while busy, including the cycle in
  // which the final done returns the scheduler to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
    end else if (frame_tick && (state != ST_IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign tile_idx = idx;
  assign td_start = td_start_q;
  assign overrun  = overrun_q;

  assign clr_bus = {clr_x, clr_y, clr_rgb, clr_plot};
  assign td_bus  = {td_x_o, td_y_o, td_rgb, td_plot};

  vga_draw_scheduler_plot_bus_mux u_plot_bus_mux (
    .grant   (grant),
    .clr_bus (clr_bus),
    .td_bus  (td_bus),
    .vga_bus (vga_bus)
  );

  assign vga_x    = vga_bus.x;
  assign vga_y    = vga_bus.y;
  assign vga_rgb  = vga_bus.rgb;
  assign vga_plot = vga_bus.plot;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// tb/tb_vga_draw_scheduler.sv - randomized self-checking bench for vga_draw_scheduler

module tb_vga_draw_scheduler;

  localparam int MAX_T = 4;
  localparam int WD    = 128;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic [2:0]  tile_count = '0;
  logic [1:0]  tile_idx;
  logic [11:0] tile_addr;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic        clr_start;
  logic        clr_done = 1'b0;
  logic [7:0]  clr_x = '0;
  logic [6:0]  clr_y = '0;
  logic [23:0] clr_rgb = '0;
  logic        clr_plot = 1'b0;
  logic        td_start;
  logic [11:0] td_addr;
  logic [7:0]  td_x;
  logic [6:0]  td_y;
  logic        td_done = 1'b0;
  logic [7:0]  td_x_o = '0;
  logic [6:0]  td_y_o = '0;
  logic [23:0] td_rgb = '0;
  logic        td_plot = 1'b0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [23:0] vga_rgb;
  logic        vga_plot;
  logic        busy;
  logic        overrun;
  logic        wd_abort;

  always #5 clk = ~clk;

  vga_draw_scheduler #(.MAX_TILES(MAX_T), .WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .tile_count(tile_count),
    .tile_idx(tile_idx), .tile_addr(tile_addr), .tile_x(tile_x), .tile_y(tile_y),
    .clr_start(clr_start), .clr_done(clr_done),
    .clr_x(clr_x), .clr_y(clr_y), .clr_rgb(clr_rgb), .clr_plot(clr_plot),
    .td_start(td_start), .td_addr(td_addr), .td_x(td_x), .td_y(td_y), .td_done(td_done),
    .td_x_o(td_x_o), .td_y_o(td_y_o), .td_rgb(td_rgb), .td_plot(td_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rgb(vga_rgb), .vga_plot(vga_plot),
    .busy(busy), .overrun(overrun), .wd_abort(wd_abort)
  );

  // Tile table model: combinational lookup by tile_idx.
  logic [11:0] tbl_addr [MAX_T];
  logic [7:0]  tbl_x    [MAX_T];
  logic [6:0]  tbl_y    [MAX_T];
  assign tile_addr = tbl_addr[tile_idx];
  assign tile_x    = tbl_x[tile_idx];
  assign tile_y    = tbl_y[tile_idx];

  int n_checks = 0;
  int n_errors = 0;
  bit exp_overrun = 1'b0;

  // Start pulse monitors, sampled away from the active edge.
  int clr_pulses = 0;
  int td_pulses  = 0;
  always @(negedge clk) begin
    if (clr_start === 1'b1) clr_pulses++;
    if (td_start === 1'b1) td_pulses++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] vga_bus();
    return {vga_x, vga_y, vga_rgb, vga_plot};
  endfunction

  // Put random traffic on both engine buses (plot high) and check that
  // the adapter sees exactly the expected one: 0 none, 1 clear, 2 tile.
  task automatic drive_and_check_mux(input string tag, input int who);
    logic [39:0] exp;
    clr_x = 8'($urandom); clr_y = 7'($urandom); clr_rgb = 24'($urandom); clr_plot = 1'b1;
    td_x_o = 8'($urandom); td_y_o = 7'($urandom); td_rgb = 24'($urandom); td_plot = 1'b1;
    #1;
    case (who)
      1:       exp = {clr_x, clr_y, clr_rgb, clr_plot};
      2:       exp = {td_x_o, td_y_o, td_rgb, td_plot};
      default: exp = '0;
    endcase
    check_eq(tag, 64'(vga_bus()), 64'(exp));
  endtask

  task automatic randomize_table();
    for (int i = 0; i < MAX_T; i++) begin
      tbl_addr[i] = 12'($urandom_range(1, 4095));
      tbl_x[i]    = 8'($urandom);
      tbl_y[i]    = 7'($urandom);
    end
  endtask

  // One full frame driven from the rules: clear once, then min(tc,MAX_T)
  // tiles in index order, each with parameters from the table.
  task automatic run_frame(input int tc, input bit tick_at_end, input int max_clr_wait);
    int n, c0, t0, d;
    n  = (tc > MAX_T) ? MAX_T : tc;
    c0 = clr_pulses;
    t0 = td_pulses;
    randomize_table();

    frame_tick = 1'b1; tile_count = 3'(tc);
    step();
    frame_tick = 1'b0;
    check_eq("clr_start_go", 64'(clr_start), 64'(1));
    check_eq("busy_go", 64'(busy), 64'(1));

    step();
    check_eq("clr_start_wait", 64'(clr_start), 64'(0));
    drive_and_check_mux("vga_follows_clr", 1);
    d = $urandom_range(0, max_clr_wait);
    for (int j = 0; j < d; j++) begin
      if ($urandom_range(0, 7) == 0) td_done = 1'b1;
      step();
      td_done = 1'b0;
    end
    check_eq("still_clr_grant", 64'(busy), 64'(1));
    clr_done = 1'b1;
    step();
    clr_done = 1'b0;

    for (int k = 0; k < n; k++) begin
      check_eq("tile_idx_go", 64'(tile_idx), 64'(k));
      drive_and_check_mux("vga_none_tile_go", 0);
      step();
      check_eq("td_start", 64'(td_start), 64'(1));
      check_eq("td_addr", 64'(td_addr), 64'(tbl_addr[k]));
      check_eq("td_xy", 64'({td_x, td_y}), 64'({tbl_x[k], tbl_y[k]}));
      drive_and_check_mux("vga_follows_td", 2);
      d = $urandom_range(0, 12);
      for (int j = 0; j < d; j++) begin
        case ($urandom_range(0, 5))
          0: clr_done = 1'b1;
          1: begin frame_tick = 1'b1; tile_count = 3'($urandom); exp_overrun = 1'b1; end
          default: ;
        endcase
        step();
        clr_done = 1'b0;
        frame_tick = 1'b0;
      end
      td_done = 1'b1;
      if (k == n - 1 && tick_at_end) begin
        frame_tick = 1'b1;
        exp_overrun = 1'b1;
      end
      step();
      td_done = 1'b0;
      frame_tick = 1'b0;
    end

    check_eq("busy_end", 64'(busy), 64'(0));
    check_eq("tile_idx_end", 64'(tile_idx), 64'(0));
    drive_and_check_mux("vga_none_idle", 0);
    check_eq("overrun", 64'(overrun), 64'(exp_overrun));
    step();
    step();
    check_eq("no_restart", 64'(busy), 64'(0));
    check_eq("clr_pulses", 64'(clr_pulses - c0), 64'(1));
    check_eq("td_pulses", 64'(td_pulses - t0), 64'(n));
  endtask

  initial begin
    randomize_table();

    // Reset state.
    #2;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_outs", 64'({clr_start, td_start, overrun, wd_abort, tile_idx}), 64'(0));
    check_eq("rst_td_regs", 64'({td_addr, td_x, td_y}), 64'(0));
    check_eq("rst_vga", 64'(vga_bus()), 64'(0));
    step();
    step();
    resetn = 1'b1;

    // Idle with no tick.
    for (int i = 0; i < 6; i++) step();
    check_eq("idle_busy", 64'(busy), 64'(0));
    drive_and_check_mux("idle_vga", 0);
    check_eq("idle_no_pulses", 64'(clr_pulses + td_pulses), 64'(0));

    // Clear-only frame with a long clear, then 3 tiles, then clamped 7.
    run_frame(0, 1'b0, 100);
    run_frame(3, 1'b0, 20);
    run_frame(7, 1'b0, 20);
    run_frame(3, 1'b1, 20);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      run_frame($urandom_range(0, 7), 1'($urandom_range(0, 1)), 30);
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
    end

    // Watchdog: clear done withheld.
    begin
      int c0;
      c0 = td_pulses;
      frame_tick = 1'b1; tile_count = 3'd2;
      step();
      frame_tick = 1'b0;
      step();
      for (int c = 1; c <= WD; c++) begin
        if (c >= WD - 2) check_eq("wd_abort_cycle", 64'(wd_abort), 64'(c == WD));
        else if (wd_abort !== 1'b0) check_eq("wd_abort_early", 64'(wd_abort), 64'(0));
        if (c < WD) step();
      end
      step();
      check_eq("wd_idle", 64'(busy), 64'(0));
      check_eq("wd_no_pulse", 64'(wd_abort), 64'(0));
      drive_and_check_mux("wd_grant_none", 0);
      check_eq("wd_no_tiles", 64'(td_pulses - c0), 64'(0));
    end
    run_frame(2, 1'b0, 10);

    // Asynchronous reset while the tile drawer is granted.
    frame_tick = 1'b1; tile_count = 3'd3;
    step();
    frame_tick = 1'b0;
    step();
    clr_done = 1'b1;
    step();
    clr_done = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    exp_overrun = 1'b1;
    check_eq("pre_rst_overrun", 64'(overrun), 64'(1));
    td_plot = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_busy", 64'(busy), 64'(0));
    check_eq("async_outs", 64'({td_addr, td_x, td_y, td_start, overrun, tile_idx}), 64'(0));
    check_eq("async_vga", 64'(vga_bus()), 64'(0));
    exp_overrun = 1'b0;
    step();
    resetn = 1'b1;
    step();
    run_frame(1, 1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
